pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 30 +++
 rtl/pc_sequencer_if.sv | 34 +++
 rtl/pc_sequencer_link_stack.sv | 55 +++++
 rtl/pc_sequencer.sv | 86 ++++++++
 tb/tb_pc_sequencer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared PC-select encoding and the branch displacement helper for the PC sequencer.
// Combinational only; no latency or backpressure of its own.
package pc_pkg;

    localparam int PC_MAX_W = 64;

    typedef enum logic [2:0] {
        PC_SEQ,
        PC_BR,
        PC_CALL,
        PC_RET,
        PC_REDIR,
        PC_HOLD
    } pc_sel_e;

    // Word offset -> signed byte displacement: bits above ofs_w+1 take the sign.
    function automatic logic [PC_MAX_W-1:0] ofs_extend(
        input logic [PC_MAX_W-1:0] ofs,
        input logic                sgn,
        input int                  ofs_w
    );
        logic [PC_MAX_W-1:0] r;
        r = ofs << 2;
        for (int i = 0; i < PC_MAX_W; i++) begin
            if (i >= ofs_w + 2) r[i] = sgn;
        end
        return r;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/PC bundle between the front end (master) and the PC sequencer (slave).
// Wires only; stall is the sole hold mechanism, there is no ready handshake.
interface pc_sequencer_if #(
    parameter int WIDTH = 64,
    parameter int OFS_W = 26,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             stall;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic             br_taken;
    logic [OFS_W-1:0] br_offset;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_prev;
    logic [CNT_W-1:0] ras_count;
    logic             ras_underflow;
    logic             ras_overflow;
    logic             sel_err;

    modport master (
        output stall, redirect, redirect_pc, br_taken, br_offset, call, ret,
        input  pc, pc_prev, ras_count, ras_underflow, ras_overflow, sel_err
    );

    modport slave (
        input  stall, redirect, redirect_pc, br_taken, br_offset, call, ret,
        output pc, pc_prev, ras_count, ras_underflow, ras_overflow, sel_err
    );

endinterface

// File: rtl/pc_sequencer_link_stack.sv
// Circular return-address stack; push overwrites the oldest entry when full.
// Pointer/count update and overflow/underflow pulses one clock after push/pop; no backpressure.
module link_stack #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             push_data,
    output logic [WIDTH-1:0]             top,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] top_ptr;
    logic             full;
    logic             empty;

    assign top_ptr = wr_ptr - PTR_W'(1);
    assign top     = mem[top_ptr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= push & full;
            underflow <= pop & ~push & empty;
            if (push) begin
                // Pointer wraps onto the oldest slot; count saturates at DEPTH.
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (!full) count <= count + CNT_W'(1);
            end else if (pop && !empty) begin
                wr_ptr <= top_ptr;
                count  <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selector (redirect > stall > call/ret > branch > sequential) with link stack.
// Every selection lands on pc one clock later; stall holds pc, pc_prev and the stack.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               INC       = 4,
    parameter int               OFS_W     = 26,
    parameter int               DEPTH     = 4
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    pc_sel_e             sel;
    logic [PC_MAX_W-1:0] disp_full;
    logic [WIDTH-1:0]    br_tgt;
    logic [WIDTH-1:0]    link_pc;
    logic [WIDTH-1:0]    link_top;
    logic [WIDTH-1:0]    next_pc;
    logic [CNT_W-1:0]    stk_count;
    logic                stk_push;
    logic                stk_pop;

    always_comb begin
        sel = PC_SEQ;
        if (bus.redirect)      sel = PC_REDIR;
        else if (bus.stall)    sel = PC_HOLD;
        else if (bus.call)     sel = PC_CALL;
        else if (bus.ret)      sel = PC_RET;
        else if (bus.br_taken) sel = PC_BR;
    end

    assign disp_full = ofs_extend(PC_MAX_W'(bus.br_offset), bus.br_offset[OFS_W-1], OFS_W);
    assign br_tgt    = bus.pc + disp_full[WIDTH-1:0];
    assign link_pc   = bus.pc + WIDTH'(INC);
    assign stk_push  = (sel == PC_CALL);
    assign stk_pop   = (sel == PC_RET);

    always_comb begin
        next_pc = link_pc;
        case (sel)
            PC_REDIR:       next_pc = bus.redirect_pc;
            PC_HOLD:        next_pc = bus.pc;
            PC_CALL, PC_BR: next_pc = br_tgt;
            // Return on an empty stack restarts from the reset vector.
            PC_RET:         next_pc = (stk_count == '0) ? RESET_VEC : link_top;
            default:        next_pc = link_pc;
        endcase
    end

    link_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (link_pc),
        .top       (link_top),
        .count     (stk_count),
        .overflow  (bus.ras_overflow),
        .underflow (bus.ras_underflow)
    );

    assign bus.ras_count = stk_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.pc      <= RESET_VEC;
            bus.pc_prev <= RESET_VEC;
            bus.sel_err <= 1'b0;
        end else begin
            bus.sel_err <= (sel == PC_CALL) & bus.ret;
            if (sel != PC_HOLD) begin
                bus.pc      <= next_pc;
                bus.pc_prev <= bus.pc;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Vector table plus hand sequences for the PC sequencer; expectations queued at drive time.
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pc_sequencer_if #(.WIDTH(64), .OFS_W(26), .DEPTH(4)) bus ();

    pc_sequencer #(
        .WIDTH     (64),
        .RESET_VEC (64'h0),
        .INC       (4),
        .OFS_W     (26),
        .DEPTH     (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic        stall;
        logic        redirect;
        logic [63:0] rpc;
        logic        br;
        logic [25:0] ofs;
        logic        call;
        logic        ret;
        logic [63:0] e_pc;
        logic [63:0] e_prev;
        logic [2:0]  e_cnt;
        logic        e_uf;
        logic        e_of;
        logic        e_se;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(string n, bit st, bit rd, logic [63:0] rpc, bit br,
                                logic [25:0] ofs, bit c, bit r, logic [63:0] epc,
                                logic [63:0] eprev, int cnt, bit uf, bit of, bit se);
        vec_t v;
        v.name = n; v.stall = st; v.redirect = rd; v.rpc = rpc; v.br = br; v.ofs = ofs;
        v.call = c; v.ret = r; v.e_pc = epc; v.e_prev = eprev; v.e_cnt = 3'(cnt);
        v.e_uf = uf; v.e_of = of; v.e_se = se;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.stall       = v.stall;
        bus.redirect    = v.redirect;
        bus.redirect_pc = v.rpc;
        bus.br_taken    = v.br;
        bus.br_offset   = v.ofs;
        bus.call        = v.call;
        bus.ret         = v.ret;
    endtask

    task automatic pop_cmp();
        vec_t e;
        if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = exp_q.pop_front();
        chk({e.name, ".pc"},      bus.pc,                    e.e_pc);
        chk({e.name, ".pc_prev"}, bus.pc_prev,               e.e_prev);
        chk({e.name, ".count"},   64'(bus.ras_count),        64'(e.e_cnt));
        chk({e.name, ".uf"},      64'(bus.ras_underflow),    64'(e.e_uf));
        chk({e.name, ".of"},      64'(bus.ras_overflow),     64'(e.e_of));
        chk({e.name, ".sel_err"}, 64'(bus.sel_err),          64'(e.e_se));
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        drive(v);
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        pop_cmp();
    endtask

    task automatic release_step(input vec_t v);
        @(negedge clk);
        drive(v);
        reset = 1'b0;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        pop_cmp();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".pc"},      bus.pc,                 64'h0);
        chk({tag, ".pc_prev"}, bus.pc_prev,            64'h0);
        chk({tag, ".count"},   64'(bus.ras_count),     64'h0);
        chk({tag, ".pulses"},  64'({bus.ras_underflow, bus.ras_overflow, bus.sel_err}), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t idle;
        idle = mk("idle", 0,0,0, 0,0, 0,0, 0,0,0, 0,0,0);
        reset = 1'b1;
        drive(idle);

        // name, stall, redir, rpc, br, ofs, call, ret, exp pc, exp prev, cnt, uf, of, se
        vecs.push_back(mk("seq1",       0,0,0,        0,0,           0,0, 64'h8,    64'h4,    0,0,0,0));
        vecs.push_back(mk("seq2",       0,0,0,        0,0,           0,0, 64'hC,    64'h8,    0,0,0,0));
        vecs.push_back(mk("redir100",   0,1,64'h100,  0,0,           0,0, 64'h100,  64'hC,    0,0,0,0));
        vecs.push_back(mk("br_m2",      0,0,0,        1,26'h3FFFFFE, 0,0, 64'hF8,   64'h100,  0,0,0,0));
        vecs.push_back(mk("redir0",     0,1,64'h0,    0,0,           0,0, 64'h0,    64'hF8,   0,0,0,0));
        vecs.push_back(mk("br_m1",      0,0,0,        1,26'h3FFFFFF, 0,0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 0,0,0,0));
        vecs.push_back(mk("wrap",       0,0,0,        0,0,           0,0, 64'h0,    64'hFFFF_FFFF_FFFF_FFFC, 0,0,0,0));
        vecs.push_back(mk("br_maxpos",  0,0,0,        1,26'h1FFFFFF, 0,0, 64'h7FFFFFC, 64'h0, 0,0,0,0));
        vecs.push_back(mk("redir40",    0,1,64'h40,   0,0,           0,0, 64'h40,   64'h7FFFFFC, 0,0,0,0));
        vecs.push_back(mk("call16",     0,0,0,        0,26'd16,      1,0, 64'h80,   64'h40,   1,0,0,0));
        vecs.push_back(mk("seq84",      0,0,0,        0,0,           0,0, 64'h84,   64'h80,   1,0,0,0));
        vecs.push_back(mk("ret_br",     0,0,0,        1,26'd16,      0,1, 64'h44,   64'h84,   0,0,0,0));
        vecs.push_back(mk("stall_rd",   1,1,64'h2000, 0,0,           0,0, 64'h2000, 64'h44,   0,0,0,0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk("stall",  1,0,0,        1,26'd5,       0,0, 64'h2000, 64'h44,   0,0,0,0));
        vecs.push_back(mk("stall_call", 1,0,0,        0,26'd5,       1,0, 64'h2000, 64'h44,   0,0,0,0));
        vecs.push_back(mk("call_ret",   0,0,0,        0,26'd4,       1,1, 64'h2010, 64'h2000, 1,0,0,1));
        vecs.push_back(mk("se_clear",   0,0,0,        0,0,           0,0, 64'h2014, 64'h2010, 1,0,0,0));
        vecs.push_back(mk("ret2004",    0,0,0,        0,0,           0,1, 64'h2004, 64'h2014, 0,0,0,0));
        vecs.push_back(mk("c1",         0,0,0,        0,26'd16,      1,0, 64'h2044, 64'h2004, 1,0,0,0));
        vecs.push_back(mk("c2",         0,0,0,        0,26'd16,      1,0, 64'h2084, 64'h2044, 2,0,0,0));
        vecs.push_back(mk("c3",         0,0,0,        0,26'd16,      1,0, 64'h20C4, 64'h2084, 3,0,0,0));
        vecs.push_back(mk("c4",         0,0,0,        0,26'd16,      1,0, 64'h2104, 64'h20C4, 4,0,0,0));
        vecs.push_back(mk("c5_ovf",     0,0,0,        0,26'd16,      1,0, 64'h2144, 64'h2104, 4,0,1,0));
        vecs.push_back(mk("of_clear",   0,0,0,        0,0,           0,0, 64'h2148, 64'h2144, 4,0,0,0));
        vecs.push_back(mk("r1",         0,0,0,        0,0,           0,1, 64'h2108, 64'h2148, 3,0,0,0));
        vecs.push_back(mk("r2",         0,0,0,        0,0,           0,1, 64'h20C8, 64'h2108, 2,0,0,0));
        vecs.push_back(mk("r3",         0,0,0,        0,0,           0,1, 64'h2088, 64'h20C8, 1,0,0,0));
        vecs.push_back(mk("r4",         0,0,0,        0,0,           0,1, 64'h2048, 64'h2088, 0,0,0,0));
        vecs.push_back(mk("r5_unf",     0,0,0,        0,0,           0,1, 64'h0,    64'h2048, 0,1,0,0));
        vecs.push_back(mk("uf_clear",   0,0,0,        0,0,           0,0, 64'h4,    64'h0,    0,0,0,0));
        vecs.push_back(mk("call_pre",   0,0,0,        0,26'd1,       1,0, 64'h8,    64'h4,    1,0,0,0));

        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");

        release_step(mk("seq0", 0,0,0, 0,0, 0,0, 64'h4, 64'h0, 0,0,0,0));
        foreach (vecs[i]) step(vecs[i]);

        // Asynchronous reset in the middle of a cycle while a call is being presented.
        @(negedge clk);
        drive(mk("busy", 0,0,0, 1,26'd8, 1,0, 0,0,0, 0,0,0));
        #2;
        reset = 1'b1;
        #1;
        chk_reset_state("async_rst");
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("rst_hold");

        release_step(mk("post_rst",     0,0,0, 0,0, 0,0, 64'h4, 64'h0, 0,0,0,0));
        step(mk("post_rst_ret",         0,0,0, 0,0, 0,1, 64'h0, 64'h4, 0,1,0,0));
        step(mk("post_rst_seq",         0,0,0, 0,0, 0,0, 64'h4, 64'h0, 0,0,0,0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
